// File: rtl/switch_gesture_decoder.sv
// switch_gesture_decoder
// Turns debounced switch trigger pulses into 1..MAX_TAPS tap gestures, where
// a gesture is the burst of pulses inside one window. Each gesture is
// presented as a single pending event with a valid/ready handshake.
// Optional feature: define SWITCH_GESTURE_STUCK_EN to report a pulse held
// high for STUCK_CYCLES as a stuck event (evt_taps = 0) and then wait for the
// switch to be released.

module switch_gesture_decoder #(
  parameter logic [24:0] WIN_CYCLES   = 25'd50_000_000,
  parameter logic [15:0] MIN_PULSE    = 16'd400,
  parameter int          MAX_TAPS     = 3,
  parameter int          TAP_W        = 2,
  parameter logic [24:0] STUCK_CYCLES = 25'd25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [TAP_W-1:0] evt_taps,
  output logic             evt_lost,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    MEAS,
    GAP,
`ifdef SWITCH_GESTURE_STUCK_EN
    REPORT,
    STUCK
`else
    REPORT
`endif
  } state_t;

  state_t           state;
  state_t           next_state;

  logic             trig_s1;
  logic             trig_s2;
  logic             trig_d;
  logic             rise;
  logic             fall;

  logic [15:0]      hi_cnt;
  logic [24:0]      win_cnt;
  logic [TAP_W-1:0] taps;
  logic [TAP_W-1:0] taps_nxt;
  logic [TAP_W-1:0] rpt_taps;
  logic             rpt_lost;
  logic             lost_pend;

  logic             win_done;
  logic             long_pulse;
  logic             enter_report;

  // Two-flop synchroniser for the pin, then registered rise/fall strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      trig_s1 <= trig_in;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
      rise    <= trig_s2 & ~trig_d;
      fall    <= ~trig_s2 & trig_d;
    end
  end

  // High-time of the current pulse, restarted on each rise, saturating at MIN_PULSE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_cnt <= '0;
    end else if (trig_s2 && !trig_d) begin
      hi_cnt <= 16'd1;
    end else if (trig_s2 && (hi_cnt < MIN_PULSE)) begin
      hi_cnt <= hi_cnt + 16'd1;
    end
  end

`ifdef SWITCH_GESTURE_STUCK_EN
  logic [24:0] stuck_cnt;
  logic        stuck_hit;

  // Separate long-range high-time counter used to spot a switch stuck closed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stuck_cnt <= '0;
    end else if (trig_s2 && !trig_d) begin
      stuck_cnt <= 25'd1;
    end else if (trig_s2 && (stuck_cnt < STUCK_CYCLES)) begin
      stuck_cnt <= stuck_cnt + 25'd1;
    end
  end

  assign stuck_hit = (stuck_cnt >= STUCK_CYCLES);
`else
  logic unused_stuck_cycles;
  assign unused_stuck_cycles = ^STUCK_CYCLES;
`endif

  assign win_done     = (win_cnt >= WIN_CYCLES);
  assign long_pulse   = (hi_cnt >= MIN_PULSE);
  assign enter_report = (next_state == REPORT) && (state != REPORT);

  // Gesture window: held at zero while idle, runs through MEAS and GAP, saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
    end else if (state == IDLE) begin
      win_cnt <= '0;
    end else if (((state == MEAS) || (state == GAP)) && !win_done) begin
      win_cnt <= win_cnt + 25'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and tap-count decisions; falls are resolved against the window.
  always_comb begin
    next_state = state;
    taps_nxt   = taps;
    case (state)
      IDLE: begin
        taps_nxt = '0;
        if (rise) begin
          next_state = MEAS;
        end
      end
      MEAS: begin
        if (fall) begin
          if (long_pulse) begin
            taps_nxt = taps + TAP_W'(1);
            if (taps_nxt == TAP_W'(MAX_TAPS)) begin
              next_state = REPORT;
            end else if (win_done) begin
              next_state = REPORT;
            end else begin
              next_state = GAP;
            end
          end else if (taps == '0) begin
            next_state = IDLE;
          end else if (win_done) begin
            next_state = REPORT;
          end else begin
            next_state = GAP;
          end
        end
`ifdef SWITCH_GESTURE_STUCK_EN
        else if (stuck_hit) begin
          taps_nxt   = '0;
          next_state = REPORT;
        end
`endif
      end
      GAP: begin
        if (win_done) begin
          next_state = REPORT;
        end else if (rise) begin
          next_state = MEAS;
        end
      end
      REPORT: begin
        if (evt_ready) begin
`ifdef SWITCH_GESTURE_STUCK_EN
          if (rpt_taps == '0) begin
            next_state = STUCK;
          end else begin
            next_state = IDLE;
          end
`else
          next_state = IDLE;
`endif
        end
      end
`ifdef SWITCH_GESTURE_STUCK_EN
      STUCK: begin
        if (!trig_d) begin
          next_state = IDLE;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Tap counter and the event snapshot frozen on entry to REPORT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps     <= '0;
      rpt_taps <= '0;
      rpt_lost <= 1'b0;
    end else begin
      taps <= taps_nxt;
      if (enter_report) begin
        rpt_taps <= taps_nxt;
        rpt_lost <= lost_pend;
      end
    end
  end

  // Remember rises that land while an event is pending (including one coinciding with window close).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lost_pend <= 1'b0;
    end else if (enter_report) begin
      lost_pend <= (state == GAP) && rise;
    end else if ((state == REPORT) && rise) begin
      lost_pend <= 1'b1;
    end
  end

  // Outputs decoded from state; event fields read zero when nothing is pending.
  always_comb begin
    evt_valid = (state == REPORT);
    evt_taps  = evt_valid ? rpt_taps : '0;
    evt_lost  = evt_valid & rpt_lost;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_switch_gesture_decoder.sv
// tb_switch_gesture_decoder
// Directed and randomised tap gestures against a pulse-list reference model.
// Honours SWITCH_GESTURE_STUCK_EN for the stuck-switch scenario.

module tb_switch_gesture_decoder;

  localparam int WIN   = 2000;
  localparam int MINP  = 400;
  localparam int MAXT  = 3;
  localparam int STUCK = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trig_in = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_taps;
  logic       evt_lost;
  logic       busy;

  typedef struct {
    int cyc;
    int taps;
    int lost;
  } ev_t;

  ev_t  ev_q[$];
  ev_t  mon_ev;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_rise = 0;
  logic busy_q = 1'b0;
  int   last_ev_cyc = -1;
  int   g_w[$];
  int   g_g[$];
  logic hold_mon = 1'b0;
  int   hold_cnt = 0;
  int   hold_ok = 0;

  switch_gesture_decoder #(
    .WIN_CYCLES  (25'd2000),
    .MIN_PULSE   (16'd400),
    .MAX_TAPS    (3),
    .TAP_W       (2),
    .STUCK_CYCLES(25'd5000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trig_in  (trig_in),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_taps (evt_taps),
    .evt_lost (evt_lost),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record handshakes, busy rises and the held-event stability window.
  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      mon_ev.cyc  = cyc;
      mon_ev.taps = int'(evt_taps);
      mon_ev.lost = int'(evt_lost);
      ev_q.push_back(mon_ev);
    end
    if (busy && !busy_q) busy_rise = cyc;
    busy_q = busy;
    if (hold_mon) begin
      hold_cnt++;
      if (evt_valid && (evt_taps == 2'd1) && !evt_lost) hold_ok++;
    end
  end

  initial begin
    #(20 * 95000);
    $display("[TB] FAIL watchdog: observed no finish, expected finish within 95000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one pin pulse of width cycles followed by gap low cycles.
  // re/fe are the clock edges that first sample the pin high / low.
  task automatic apply_stimulus(input int width, input int gap, output int re, output int fe);
    @(posedge clk);
    #1;
    trig_in = 1'b1;
    re = cyc + 1;
    repeat (width) @(posedge clk);
    #1;
    trig_in = 1'b0;
    fe = cyc + 1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic add_pulse(input int width, input int gap);
    g_w.push_back(width);
    g_g.push_back(gap);
  endtask

  // Reference: glitches before the first tap are ignored and restart the window;
  // MAX_TAPS taps report 3 edges after the pin fall is sampled; otherwise the
  // event comes WIN cycles after the window start plus the 4-edge pipeline.
  function automatic void predict(input int r[$], input int f[$], output bit has,
                                  output int ev_at, output int taps_o);
    int t = 0;
    int start = 0;
    has = 1'b0;
    ev_at = 0;
    taps_o = 0;
    for (int i = 0; i < r.size(); i++) begin
      if (t == 0) start = r[i];
      if ((f[i] - r[i]) >= MINP) begin
        t++;
        if (t == MAXT) begin
          has = 1'b1;
          ev_at = f[i] + 3;
          taps_o = t;
          return;
        end
      end
    end
    if (t > 0) begin
      has = 1'b1;
      ev_at = start + WIN + 4;
      taps_o = t;
    end
  endfunction

  task automatic run_gesture(input string tag, input int exp_lost);
    int r[$];
    int f[$];
    int re, fe, ee, et;
    bit has;
    foreach (g_w[i]) begin
      apply_stimulus(g_w[i], g_g[i], re, fe);
      r.push_back(re);
      f.push_back(fe);
    end
    predict(r, f, has, ee, et);
    last_ev_cyc = -1;
    if (has) begin
      wait_until(ee + 10);
      check_output({tag, " event count"}, ev_q.size(), 1);
      if (ev_q.size() > 0) begin
        last_ev_cyc = ev_q[0].cyc;
        check_output({tag, " event cycle"}, ev_q[0].cyc, ee);
        check_output({tag, " taps"}, ev_q[0].taps, et);
        check_output({tag, " lost"}, ev_q[0].lost, exp_lost);
      end
    end else begin
      wait_until(f[f.size()-1] + 20);
      check_output({tag, " event count"}, ev_q.size(), 0);
    end
    check_output({tag, " busy after"}, int'(busy), 0);
    ev_q.delete();
    g_w.delete();
    g_g.delete();
  endtask

  initial begin
    int re, fe, re2, fe2, ee, n;
    bit in_range;

    #35;
    check_output("reset evt_valid", int'(evt_valid), 0);
    check_output("reset evt_taps", int'(evt_taps), 0);
    check_output("reset evt_lost", int'(evt_lost), 0);
    check_output("reset busy", int'(busy), 0);
    rst = 1'b1;
    wait_cycles(5);

    add_pulse(500, 300);
    run_gesture("single tap", 0);
    check_output("single tap busy-to-valid", last_ev_cyc - busy_rise, WIN + 1);

    add_pulse(500, 200);
    add_pulse(500, 300);
    run_gesture("two taps", 0);

    add_pulse(500, 100);
    add_pulse(500, 100);
    add_pulse(500, 100);
    run_gesture("three taps", 0);

    add_pulse(100, 300);
    run_gesture("glitch only", 0);

    add_pulse(100, 300);
    add_pulse(500, 300);
    run_gesture("glitch then tap", 0);

    add_pulse(399, 300);
    run_gesture("pulse 399", 0);

    add_pulse(400, 300);
    run_gesture("pulse 400", 0);

    // Event held with ready low while one extra pulse arrives.
    evt_ready = 1'b0;
    apply_stimulus(500, 0, re, fe);
    ee = re + WIN + 4;
    wait_until(ee);
    check_output("held valid", int'(evt_valid), 1);
    check_output("held taps", int'(evt_taps), 1);
    hold_mon = 1'b1;
    apply_stimulus(500, 200, re2, fe2);
    wait_until(ee + 3000);
    hold_mon = 1'b0;
    check_output("held stable cycles", hold_ok, hold_cnt);
    check_output("held no handshake", ev_q.size(), 0);
    evt_ready = 1'b1;
    wait_cycles(1);
    check_output("released valid", int'(evt_valid), 0);
    check_output("released handshake", ev_q.size(), 1);
    ev_q.delete();
    wait_cycles(20);
    add_pulse(500, 300);
    run_gesture("after loss", 1);
    add_pulse(500, 300);
    run_gesture("loss cleared", 0);

    // Asynchronous reset in GAP with two taps counted.
    apply_stimulus(500, 200, re, fe);
    apply_stimulus(500, 100, re, fe);
    #5;
    rst = 1'b0;
    #1;
    check_output("mid reset evt_valid", int'(evt_valid), 0);
    check_output("mid reset evt_taps", int'(evt_taps), 0);
    check_output("mid reset evt_lost", int'(evt_lost), 0);
    check_output("mid reset busy", int'(busy), 0);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2500);
    check_output("after reset no event", ev_q.size(), 0);
    check_output("after reset busy", int'(busy), 0);
    ev_q.delete();

    // Switch held closed for 8000 cycles.
    apply_stimulus(8000, 300, re, fe);
`ifdef SWITCH_GESTURE_STUCK_EN
    check_output("stuck event count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      in_range = ((ev_q[0].cyc - re) >= STUCK - 10) && ((ev_q[0].cyc - re) <= STUCK + 10);
      check_output("stuck taps", ev_q[0].taps, 0);
      check_output("stuck lost", ev_q[0].lost, 0);
      check_output("stuck timing", int'(in_range), 1);
    end
    ev_q.delete();
    wait_until(fe + WIN + 50);
    check_output("stuck no repeat", ev_q.size(), 0);
    check_output("stuck released busy", int'(busy), 0);
    ev_q.delete();
    add_pulse(500, 300);
    run_gesture("after stuck", 0);
`else
    wait_until(fe + 13);
    check_output("long pulse event count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      check_output("long pulse event cycle", ev_q[0].cyc, fe + 3);
      check_output("long pulse taps", ev_q[0].taps, 1);
      check_output("long pulse lost", ev_q[0].lost, 0);
    end
    ev_q.delete();
    wait_cycles(20);
`endif

    // Randomised gestures: 1..3 pulses, each a tap or a glitch, all inside one window.
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3, 0) != 0) add_pulse($urandom_range(500, 400), $urandom_range(200, 100));
        else add_pulse($urandom_range(360, 40), $urandom_range(200, 100));
      end
      run_gesture($sformatf("random %0d", k), 0);
      wait_cycles(10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
